mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the pipeline fetch port (I) and the
//  MEMORY ACCESS stage load/store port (D). One transaction outstanding at a time.
//  Data side has priority, with an anti-starvation limit for fetch. Sits between the
//  datapath memory interfaces and the memory; fetch stalls derive from i_gnt/i_rvalid.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width (DATA_W/8 byte strobes)
//  MAX_D_BURST  4   consecutive D grants allowed while i_req pending (>=1)
//  CNT_W        32  width of performance counters
// PORTS
//  clk          in   1         system clock, all flops rising edge
//  resetn       in   1         asynchronous, active-low reset
//  i_req        in   1         fetch request; held with i_addr until i_gnt
//  i_addr       in   ADDR_W    fetch address
//  i_gnt        out  1         fetch request accepted by memory this cycle
//  i_rvalid     out  1         one-cycle pulse: i_rdata valid
//  i_rdata      out  DATA_W    fetch read data
//  d_req        in   1         data request; held with payload until d_gnt
//  d_we         in   1         1 = store, 0 = load
//  d_addr       in   ADDR_W    data address
//  d_wdata      in   DATA_W    store data
//  d_wstrb      in   DATA_W/8  store byte enables
//  d_gnt        out  1         data request accepted this cycle
//  d_rvalid     out  1         one-cycle pulse: load data / store ack
//  d_rdata      out  DATA_W    load data
//  mem_req      out  1         request to memory
//  mem_we       out  1         write enable (only from D)
//  mem_addr     out  ADDR_W    address to memory
//  mem_wdata    out  DATA_W    write data
//  mem_wstrb    out  DATA_W/8  write strobes (0 for reads)
//  mem_gnt      in   1         memory accepts mem_req this cycle
//  mem_rvalid   in   1         response pulse, earliest the cycle after mem_gnt
//  mem_rdata    in   DATA_W    read data, valid with mem_rvalid
//  perf_i_wait  out  CNT_W     cycles i_req high and not granted
//  perf_d_gnt   out  CNT_W     number of D grants
// BEHAVIOUR
//  - FSM states: IDLE, LOCK_I, LOCK_D, WAIT_I, WAIT_D. Reset -> IDLE, burst counter 0,
//    perf counters 0; all outputs 0 during reset.
//  - IDLE: pick owner: D if d_req and !(i_req and burst==MAX_D_BURST), else I if i_req.
//    Drive mem_* from owner combinationally. mem_gnt=1 -> owner gnt=1, go WAIT_x;
//    mem_gnt=0 -> go LOCK_x (owner frozen, no re-arbitration while memory stalls).
//  - LOCK_x: keep mem_req/payload of x; on mem_gnt -> x_gnt=1, WAIT_x.
//  - WAIT_x: mem_req=0, no grants. On mem_rvalid -> x_rvalid=1, x_rdata=mem_rdata, IDLE.
//    Next grant earliest the cycle after the response (zero-latency turnaround not done).
//  - mem_rvalid in IDLE/LOCK_x ignored (no rvalid forwarded).
//  - Stores also complete on mem_rvalid; d_rdata don't-care, d_rvalid=1 is the ack.
//  - I reads: mem_we=0, mem_wstrb=0, mem_wdata=0.
//  - Burst counter: on D grant, +1 if i_req high (saturates at MAX_D_BURST), else 0;
//    cleared on I grant.
//  - i_rdata/d_rdata are mem_rdata passthrough; only meaningful with their rvalid.
//  - Reset mid-transaction: state discarded; late mem_rvalid after release dropped.
//  - Requester dropping req before gnt is a protocol error; not checked in RTL.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: perf_i_wait increments each cycle i_req=1 and i_gnt=0;
//  perf_d_gnt increments on each d_gnt; both wrap at 2^CNT_W.
//  Not defined: no counter flops; perf_i_wait and perf_d_gnt tied to 0.
// TESTING
//  1 resetn=0 with i_req=d_req=1 -> all outputs 0, state IDLE after release.
//  2 i_req, i_addr=0x100, mem_gnt=1, mem_rvalid 2 cycles later rdata=0x00500093
//    -> i_gnt in cycle 0, i_rvalid pulse cycle 2, i_rdata=0x00500093.
//  3 i_req and d_req (load 0x2000) same cycle -> D granted first; I granted cycle
//    after d_rvalid; mem_addr sequence 0x2000 then fetch address.
//  4 MAX_D_BURST=4, d_req and i_req held, mem responds 1 cycle -> D,D,D,D,I,D... grants.
//  5 store d_we=1 addr 0x40 wdata 0xDEADBEEF wstrb 0b0011, mem_gnt low 3 cycles ->
//    stays LOCK_D, late i_req not granted; mem_we=1, mem_wstrb=0011; d_rvalid ack.
//  6 resetn low during WAIT_D, mem_rvalid after release -> no d_rvalid/i_rvalid;
//    with ARB_PERF_CNT_EN, perf_i_wait counts test-3 wait cycles exactly.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch (I) and load/store (D) ports, one transaction in flight.
// D wins ties, but fetch is forced through after MAX_D_BURST D grants; ARB_PERF_CNT_EN adds wait/grant counters.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_D_BURST = 4,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    perf_i_wait,
  output logic [CNT_W-1:0]    perf_d_gnt
);

  localparam int BURST_W = $clog2(MAX_D_BURST + 1);

  typedef enum logic [2:0] {IDLE, LOCK_I, LOCK_D, WAIT_I, WAIT_D} state_t;

  state_t             state;
  logic [BURST_W-1:0] burst;
  logic               burst_full;
  logic               sel_i;
  logic               sel_d;

  assign burst_full = (burst == BURST_W'(MAX_D_BURST));

  // Owner of the memory this cycle; everything is forced low while reset is held.
  always_comb begin
    sel_i = 1'b0;
    sel_d = 1'b0;
    if (resetn) begin
      case (state)
        IDLE: begin
          sel_d = d_req && !(i_req && burst_full);
          sel_i = !sel_d && i_req;
        end
        LOCK_I:  sel_i = 1'b1;
        LOCK_D:  sel_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_req   = sel_i || sel_d;
  assign mem_we    = sel_d && d_we;
  assign mem_addr  = sel_d ? d_addr : (sel_i ? i_addr : '0);
  assign mem_wdata = sel_d ? d_wdata : '0;
  assign mem_wstrb = (sel_d && d_we) ? d_wstrb : '0;

  assign i_gnt = sel_i && mem_gnt;
  assign d_gnt = sel_d && mem_gnt;

  // Responses are only forwarded to the port that owns the in-flight transaction.
  assign i_rvalid = resetn && (state == WAIT_I) && mem_rvalid;
  assign d_rvalid = resetn && (state == WAIT_D) && mem_rvalid;
  assign i_rdata  = resetn ? mem_rdata : '0;
  assign d_rdata  = resetn ? mem_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      burst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_d)      state <= mem_gnt ? WAIT_D : LOCK_D;
          else if (sel_i) state <= mem_gnt ? WAIT_I : LOCK_I;
        end
        LOCK_I:  if (mem_gnt) state <= WAIT_I;
        LOCK_D:  if (mem_gnt) state <= WAIT_D;
        WAIT_I:  if (mem_rvalid) state <= IDLE;
        WAIT_D:  if (mem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Burst only counts D grants that made a pending fetch wait.
      if (d_gnt) begin
        if (!i_req)          burst <= '0;
        else if (!burst_full) burst <= burst + 1'b1;
      end else if (i_gnt) begin
        burst <= '0;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [CNT_W-1:0] i_wait_cnt;
  logic [CNT_W-1:0] d_gnt_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_wait_cnt <= '0;
      d_gnt_cnt  <= '0;
    end else begin
      if (i_req && !i_gnt) i_wait_cnt <= i_wait_cnt + 1'b1;
      if (d_gnt)           d_gnt_cnt  <= d_gnt_cnt + 1'b1;
    end
  end

  assign perf_i_wait = i_wait_cnt;
  assign perf_d_gnt  = d_gnt_cnt;
`else
  assign perf_i_wait = '0;
  assign perf_d_gnt  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, MAXB = 4, CW = 32;

  logic clk = 1'b0;
  logic resetn;
  logic i_req, i_gnt, i_rvalid;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;
  logic [CW-1:0] perf_i_wait, perf_d_gnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .perf_i_wait(perf_i_wait), .perf_d_gnt(perf_d_gnt)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory: word store plus a queue of scheduled responses.
  logic [31:0] mem [int unsigned];
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t rsp_q[$];
  int cyc = 0, lat_fix = 0, last_due = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return {a[15:0], ~a[15:0]};
  endfunction

  // Reference model: who (0 none, 1 I, 2 D) holds the memory and at which stage.
  int busy_who = 0, hold_who = 0, d_run = 0;
  logic busy_we = 1'b0;
  int exp_wait = 0, exp_dg = 0;
  logic e_ig = 1'b0, e_dg = 1'b0;
  logic seen_ig, seen_dg, seen_irv, seen_drv;
  logic [31:0] last_i_rdata = '0;
  logic [31:0] acc_addr[$];

  task automatic cycle(input logic mgnt);
    logic e_req, e_irv, e_drv, e_we;
    logic [31:0] e_addr, e_wdata, w;
    logic [3:0] e_strb;
    int who, lat, due;
    @(negedge clk);
    mem_gnt    = mgnt;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else if (busy_who == 0 && $urandom_range(0, 7) == 0) begin
      mem_rvalid = 1'b1;  // stray response, must not be forwarded
    end
    #1;
    seen_ig = i_gnt; seen_dg = d_gnt; seen_irv = i_rvalid; seen_drv = d_rvalid;
    if (!resetn) begin
      check("rst_outs", 64'(|{i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_req, mem_we,
                             mem_addr, mem_wdata, mem_wstrb, perf_i_wait, perf_d_gnt}), 64'd0);
      busy_who = 0; hold_who = 0; d_run = 0; exp_wait = 0; exp_dg = 0;
      e_ig = 1'b0; e_dg = 1'b0;
    end else begin
      who = 0; e_irv = 1'b0; e_drv = 1'b0;
      if (busy_who != 0) begin
        e_irv = mem_rvalid && busy_who == 1;
        e_drv = mem_rvalid && busy_who == 2;
      end else if (hold_who != 0) who = hold_who;
      else if (d_req && !(i_req && d_run == MAXB)) who = 2;
      else if (i_req) who = 1;
      e_req   = (who != 0);
      e_ig    = (who == 1) && mgnt;
      e_dg    = (who == 2) && mgnt;
      e_we    = (who == 2) && d_we;
      e_addr  = (who == 2) ? d_addr : ((who == 1) ? i_addr : 32'd0);
      e_wdata = (who == 2) ? d_wdata : 32'd0;
      e_strb  = e_we ? d_wstrb : 4'd0;

      check("i_gnt", i_gnt, e_ig);
      check("d_gnt", d_gnt, e_dg);
      check("mem_req", mem_req, e_req);
      check("i_rvalid", i_rvalid, e_irv);
      check("d_rvalid", d_rvalid, e_drv);
      if (e_req) begin
        check("mem_addr", mem_addr, e_addr);
        check("mem_we", mem_we, e_we);
        check("mem_wdata", mem_wdata, e_wdata);
        check("mem_wstrb", mem_wstrb, e_strb);
      end
      if (e_irv) begin
        check("i_rdata", i_rdata, mem_rdata);
        last_i_rdata = i_rdata;
      end
      if (e_drv && !busy_we) check("d_rdata", d_rdata, mem_rdata);
`ifdef ARB_PERF_CNT_EN
      check("perf_i_wait", perf_i_wait, exp_wait);
      check("perf_d_gnt", perf_d_gnt, exp_dg);
`else
      check("perf_i_wait", perf_i_wait, 0);
      check("perf_d_gnt", perf_d_gnt, 0);
`endif
      if (e_irv || e_drv) busy_who = 0;
      if (who != 0 && mgnt) begin
        busy_who = who; hold_who = 0; busy_we = e_we;
        acc_addr.push_back(e_addr);
        if (who == 2) d_run = i_req ? ((d_run < MAXB) ? d_run + 1 : MAXB) : 0;
        else d_run = 0;
        if (e_we) begin
          w = mem_rd(e_addr);
          for (int b = 0; b < 4; b++) if (e_strb[b]) w[8*b +: 8] = e_wdata[8*b +: 8];
          mem[e_addr >> 2] = w;
        end
        lat = (lat_fix != 0) ? lat_fix : $urandom_range(1, 3);
        due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        last_due = due;
        rsp_q.push_back('{due, mem_rd(e_addr)});
      end else begin
        hold_who = who;
      end
      if (i_req && !e_ig) exp_wait++;
      if (e_dg) exp_dg++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  logic [9:0] gseq;
  int n;

  initial begin
    resetn = 1'b0; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h100; d_addr = 32'h200;
    d_we = 1'b0; d_wdata = '0; d_wstrb = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem[32'h100 >> 2] = 32'h00500093;
    cycle(1'b1);
    cycle(1'b1);
    resetn = 1'b1; i_req = 1'b0; d_req = 1'b0;
    cycle(1'b0);

    // single fetch, response two cycles after grant
    lat_fix = 2; i_req = 1'b1; i_addr = 32'h100;
    cycle(1'b1); check("t2_gnt", seen_ig, 1);
    i_req = 1'b0;
    cycle(1'b0); check("t2_early_rv", seen_irv, 0);
    cycle(1'b0); check("t2_rvalid", seen_irv, 1);
    check("t2_rdata", last_i_rdata, 32'h00500093);

    // simultaneous requests: data first, fetch after the load response
    lat_fix = 1; acc_addr.delete();
    i_req = 1'b1; i_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    cycle(1'b1); check("t3_d_first", seen_dg, 1);
    d_req = 1'b0;
    cycle(1'b1); check("t3_d_rv", seen_drv, 1);
    cycle(1'b1); check("t3_i_next", seen_ig, 1);
    i_req = 1'b0;
    cycle(1'b1);
    check("t3_addr0", acc_addr[0], 32'h2000);
    check("t3_addr1", acc_addr[1], 32'h300);

    // starvation limit: D,D,D,D,I,D,D,D,D,I
    i_req = 1'b1; i_addr = 32'h500; d_req = 1'b1; d_addr = 32'h44; gseq = '0; n = 0;
    for (int k = 0; k < 40 && n < 10; k++) begin
      cycle(1'b1);
      if (seen_ig || seen_dg) begin gseq = {gseq[8:0], seen_dg}; n++; end
    end
    check("t4_ngrants", n, 10);
    check("t4_order", gseq, 10'b1111011110);
    i_req = 1'b0; d_req = 1'b0;
    cycle(1'b0);

    // stalled store keeps the memory locked against a late fetch
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    cycle(1'b0);
    i_req = 1'b1; i_addr = 32'h600;
    cycle(1'b0);
    cycle(1'b0);
    check("t5_we", mem_we, 1);
    check("t5_strb", mem_wstrb, 4'b0011);
    check("t5_no_igrant", i_gnt, 0);
    cycle(1'b1); check("t5_d_gnt", seen_dg, 1);
    d_req = 1'b0; d_we = 1'b0;
    cycle(1'b0); check("t5_ack", seen_drv, 1);
    cycle(1'b1); check("t5_i_gnt", seen_ig, 1);
    i_req = 1'b0;
    cycle(1'b0);

    // reset while waiting for a load; its late response is dropped
    lat_fix = 3; d_req = 1'b1; d_addr = 32'h80;
    cycle(1'b1);
    d_req = 1'b0;
    cycle(1'b0);
    resetn = 1'b0;
    cycle(1'b0);
    resetn = 1'b1;
    cycle(1'b0);
    check("t6_no_drv", seen_drv, 0);
    check("t6_no_irv", seen_irv, 0);

    lat_fix = 0;
    for (int k = 0; k < 3000; k++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if (e_ig) i_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1'b1; i_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (e_dg) d_req = 1'b0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
        d_addr = 32'($urandom_range(0, 15)) << 2;
        d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      end
      cycle(1'($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
